branch_cond: RTL and testbench

- Consumer end of the ALU status path. Holds the architectural N/V/C/Z status register, written from the flag unit outputs.
- Evaluates branch conditions against the held flags and owns the program counter, advancing it or redirecting it on a taken branch.
- Sits between the ALU flag logic and instruction fetch.
- Detects same-cycle flag-write/branch hazards and inserts a one-cycle stall. Issues a one-cycle flush after every taken branch.

---
 rtl/branch_cond_pkg.sv | 25 ++
 rtl/branch_cond_cond_eval.sv | 28 ++
 rtl/branch_cond.sv | 130 +++++++++++++
 tb/tb_branch_cond.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/branch_cond_pkg.sv
// Shared constants and types for the branch-condition / PC block.
// Condition codes, FSM state encoding and the packed status-flag record.
package branch_cond_pkg;

  localparam logic [2:0] COND_AL  = 3'b000;
  localparam logic [2:0] COND_EQ  = 3'b001;
  localparam logic [2:0] COND_NE  = 3'b010;
  localparam logic [2:0] COND_LT  = 3'b011;
  localparam logic [2:0] COND_GE  = 3'b100;
  localparam logic [2:0] COND_LTU = 3'b101;
  localparam logic [2:0] COND_MI  = 3'b110;
  localparam logic [2:0] COND_VS  = 3'b111;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_HAZARD = 2'b01;
  localparam logic [1:0] ST_FLUSH  = 2'b10;

  typedef struct packed {
    logic n;
    logic v;
    logic c;
    logic z;
  } flags_t;

endpackage

// File: rtl/branch_cond_cond_eval.sv
// Purely combinational branch-condition evaluator: condition code plus
// held N/V/C/Z flags give a single taken/not-taken result.
module cond_eval
  import branch_cond_pkg::*;
(
  input  logic [2:0] i_cond,
  input  flags_t     i_flags,
  output logic       o_true
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // o_true unassigned, which would otherwise infer a latch.
    o_true = 1'b0;
    case (i_cond)
      COND_AL:  o_true = 1'b1;
      COND_EQ:  o_true = i_flags.z;
      COND_NE:  o_true = ~i_flags.z;
      COND_LT:  o_true = i_flags.n ^ i_flags.v;
      COND_GE:  o_true = ~(i_flags.n ^ i_flags.v);
      COND_LTU: o_true = ~i_flags.c;  // C=1 means no borrow
      COND_MI:  o_true = i_flags.n;
      COND_VS:  o_true = i_flags.v;
      default:  o_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond.sv
// Status register, branch resolution FSM and program counter.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
module branch_cond
  import branch_cond_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            PC_EN,
  input  logic            FLAG_WE,
  input  logic            N_IN,
  input  logic            V_IN,
  input  logic            C_IN,
  input  logic            Z_IN,
  input  logic            BR_VALID,
  input  logic [2:0]      BR_COND,
  input  logic [PC_W-1:0] BR_OFF,
  output logic            BR_READY,
  output logic [PC_W-1:0] PC,
  output logic            TAKEN,
  output logic            FLUSH,
  output logic            STALL,
  output logic            N,
  output logic            V,
  output logic            C,
  output logic            Z
`ifdef BRANCH_STATS_EN
  ,
  output logic [7:0]      BR_CNT,
  output logic [7:0]      TAKEN_CNT
`endif
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  flags_t          r_flags;
  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_target;
  logic            r_taken;
  logic            w_cond_true;
  logic            w_resolve;
  logic            w_take;
  logic            w_stall;

  cond_eval u_cond_eval (
    .i_cond  (BR_COND),
    .i_flags (r_flags),
    .o_true  (w_cond_true)
  );

  // Offset is already PC_W wide, so sign extension is implicit in the wrap.
  assign w_pc_inc = r_pc + PC_ONE;
  assign w_target = w_pc_inc + BR_OFF;

  assign w_resolve = BR_VALID &&
                     (((r_state == ST_IDLE) && !FLAG_WE) || (r_state == ST_HAZARD));
  assign w_take    = w_resolve && w_cond_true;
  assign w_stall   = ((r_state == ST_IDLE) && BR_VALID && FLAG_WE) ||
                     (r_state == ST_HAZARD);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_IDLE: begin
        if (BR_VALID && FLAG_WE) w_state_nxt = ST_HAZARD;
        else if (!BR_VALID && PC_EN) w_pc_nxt = w_pc_inc;
      end
      ST_HAZARD: w_state_nxt = ST_IDLE;
      // Two squash cycles: the TAKEN cycle, then the FLUSH pulse cycle.
      ST_FLUSH:  if (!r_taken) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (w_resolve) begin
      w_pc_nxt    = w_take ? w_target : w_pc_inc;
      w_state_nxt = w_take ? ST_FLUSH : ST_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_taken <= 1'b0;
      r_flags <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_taken <= w_take;
      if (FLAG_WE) r_flags <= '{n: N_IN, v: V_IN, c: C_IN, z: Z_IN};
    end
  end

`ifdef BRANCH_STATS_EN
  logic [7:0] r_br_cnt;
  logic [7:0] r_taken_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_br_cnt    <= 8'd0;
      r_taken_cnt <= 8'd0;
    end else begin
      if (w_resolve && (r_br_cnt != 8'hFF))  r_br_cnt    <= r_br_cnt + 8'd1;
      if (w_take && (r_taken_cnt != 8'hFF))  r_taken_cnt <= r_taken_cnt + 8'd1;
    end
  end

  assign BR_CNT    = r_br_cnt;
  assign TAKEN_CNT = r_taken_cnt;
`endif

  assign BR_READY = w_resolve;
  assign PC       = r_pc;
  assign TAKEN    = r_taken;
  assign FLUSH    = (r_state == ST_FLUSH) && !r_taken;
  assign STALL    = w_stall;
  assign N        = r_flags.n;
  assign V        = r_flags.v;
  assign C        = r_flags.c;
  assign Z        = r_flags.z;

endmodule

// File: tb/tb_branch_cond.sv
// Directed self-checking bench for branch_cond (PC_W=8, RESET_PC=0).
// Stats checks are compiled in when BRANCH_STATS_EN is defined.
module tb_branch_cond;

  logic       clk = 1'b0;
  logic       rst;
  logic       pc_en, flag_we, n_in, v_in, c_in, z_in;
  logic       br_valid;
  logic [2:0] br_cond;
  logic [7:0] br_off;
  logic       br_ready, taken, flush, stall, n, v, c, z;
  logic [7:0] pc;
`ifdef BRANCH_STATS_EN
  logic [7:0] br_cnt, taken_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;

  branch_cond #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .CLK(clk), .RST(rst), .PC_EN(pc_en), .FLAG_WE(flag_we),
    .N_IN(n_in), .V_IN(v_in), .C_IN(c_in), .Z_IN(z_in),
    .BR_VALID(br_valid), .BR_COND(br_cond), .BR_OFF(br_off),
    .BR_READY(br_ready), .PC(pc), .TAKEN(taken), .FLUSH(flush), .STALL(stall),
    .N(n), .V(v), .C(c), .Z(z)
`ifdef BRANCH_STATS_EN
    , .BR_CNT(br_cnt), .TAKEN_CNT(taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_flags(input logic nn, input logic vv, input logic cc, input logic zz);
    flag_we = 1'b1; n_in = nn; v_in = vv; c_in = cc; z_in = zz;
    step();
    flag_we = 1'b0;
  endtask

  // Always-taken branch from cur to tgt, then ride out both squash cycles.
  task automatic goto(input logic [7:0] cur, input logic [7:0] tgt);
    br_valid = 1'b1; br_cond = 3'b000; br_off = tgt - cur - 8'd1;
    step();
    br_valid = 1'b0;
    step();
    step();
    check("goto_pc", {24'd0, pc}, {24'd0, tgt});
  endtask

  initial begin
    rst = 1'b1; pc_en = 1'b1; flag_we = 1'b0;
    n_in = 1'b0; v_in = 1'b0; c_in = 1'b0; z_in = 1'b0;
    br_valid = 1'b0; br_cond = 3'b000; br_off = 8'h00;
    step();
    step();
    check("rst_pc", {24'd0, pc}, 32'h0);
    check("rst_flags", {28'd0, n, v, c, z}, 32'h0);
    check("rst_pulses", {29'd0, taken, flush, stall}, 32'h0);

    // Sequential advance, then async reset mid-run.
    rst = 1'b0;
    step(); check("adv_1", {24'd0, pc}, 32'h1);
    step(); check("adv_2", {24'd0, pc}, 32'h2);
    step(); check("adv_3", {24'd0, pc}, 32'h3);
    pc_en = 1'b0;
    #1 rst = 1'b1;
    #1 check("async_rst_pc", {24'd0, pc}, 32'h0);
    step();
    rst = 1'b0;

    // Taken EQ branch at 0x10, BR_VALID held through the squash cycles.
    write_flags(1'b0, 1'b0, 1'b0, 1'b1);
    check("z_latched", {28'd0, n, v, c, z}, 32'h1);
    goto(8'h00, 8'h10);
    br_valid = 1'b1; br_cond = 3'b001; br_off = 8'h05;
    #1 check("eq_ready", {31'd0, br_ready}, 32'h1);
    check("eq_nostall", {31'd0, stall}, 32'h0);
    step();
    check("eq_pc", {24'd0, pc}, 32'h16);
    check("eq_taken_pulses", {29'd0, taken, flush, stall}, 32'h4);
    check("eq_ready_squash", {31'd0, br_ready}, 32'h0);
    step();
    check("eq_flush_pulses", {29'd0, taken, flush, stall}, 32'h2);
    check("eq_flush_pc", {24'd0, pc}, 32'h16);
    check("eq_flush_ready", {31'd0, br_ready}, 32'h0);
    br_valid = 1'b0;
    step();
    check("eq_after_pc", {24'd0, pc}, 32'h16);
    check("eq_after_pulses", {29'd0, taken, flush, stall}, 32'h0);

    // Signed conditions with N=1, V=0.
    write_flags(1'b1, 1'b0, 1'b0, 1'b1);
    goto(8'h16, 8'h20);
    br_valid = 1'b1; br_cond = 3'b100; br_off = 8'h05;
    #1 check("ge_ready", {31'd0, br_ready}, 32'h1);
    step();
    br_valid = 1'b0;
    check("ge_pc", {24'd0, pc}, 32'h21);
    check("ge_taken", {31'd0, taken}, 32'h0);
    goto(8'h21, 8'h20);
    br_valid = 1'b1; br_cond = 3'b011; br_off = 8'hFC;
    step();
    br_valid = 1'b0;
    check("lt_pc", {24'd0, pc}, 32'h1D);
    check("lt_taken", {31'd0, taken}, 32'h1);
    step();
    step();

    // Hazard: flag write and branch in the same cycle.
    write_flags(1'b0, 1'b0, 1'b0, 1'b0);
    check("z_cleared", {31'd0, z}, 32'h0);
    br_valid = 1'b1; br_cond = 3'b001; br_off = 8'h03;
    flag_we = 1'b1; z_in = 1'b1;
    #1 check("hz_stall", {31'd0, stall}, 32'h1);
    check("hz_ready", {31'd0, br_ready}, 32'h0);
    step();
    flag_we = 1'b0; z_in = 1'b0;
    #1 check("hz2_z", {31'd0, z}, 32'h1);
    check("hz2_pc", {24'd0, pc}, 32'h1D);
    check("hz2_stall_ready", {30'd0, stall, br_ready}, 32'h3);
    step();
    br_valid = 1'b0;
    check("hz_pc", {24'd0, pc}, 32'h21);
    check("hz_pulses", {29'd0, taken, flush, stall}, 32'h4);
    step();
    step();

    // Wrap-around on branch target and on sequential advance.
    goto(8'h21, 8'hFE);
    br_valid = 1'b1; br_cond = 3'b000; br_off = 8'h05;
    step();
    br_valid = 1'b0;
    check("wrap_target", {24'd0, pc}, 32'h04);
    step();
    step();
    goto(8'h04, 8'hFF);
    pc_en = 1'b1;
    step();
    pc_en = 1'b0;
    check("wrap_inc", {24'd0, pc}, 32'h00);

    // Reset asserted during FLUSH abandons the branch.
    br_valid = 1'b1; br_cond = 3'b000; br_off = 8'h10;
    step();
    br_valid = 1'b0;
    step();
    check("pre_rst_flush", {31'd0, flush}, 32'h1);
    #1 rst = 1'b1;
    #1 check("rst_flush_pc", {24'd0, pc}, 32'h0);
    check("rst_flush_pulses", {29'd0, taken, flush, stall}, 32'h0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_idle", {24'd0, pc, 5'd0, taken, flush, stall}, 32'h0);

`ifdef BRANCH_STATS_EN
    check("cnt_rst", {16'd0, br_cnt, taken_cnt}, 32'h0);
    br_valid = 1'b1; br_cond = 3'b000; br_off = 8'h00;
    step();
    step();
    br_valid = 1'b0;
    step();
    check("cnt_flush_drop", {24'd0, br_cnt}, 32'h1);
    for (int i = 0; i < 300; i++) begin
      br_valid = 1'b1;
      step();
      br_valid = 1'b0;
      step();
      step();
    end
    check("taken_cnt_sat", {24'd0, taken_cnt}, 32'hFF);
    check("br_cnt_sat", {24'd0, br_cnt}, 32'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
